// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator floor scheduler.
package elevator_pkg;

    localparam int FLOOR_W    = 4;
    localparam int MAX_FLOORS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    // Floors strictly above (up=1) or strictly below (up=0) f, limited to the served floors.
    function automatic logic [MAX_FLOORS-1:0] ahead_mask(
        input logic [FLOOR_W-1:0] f,
        input logic               up,
        input int                 floors
    );
        logic [MAX_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i < floors) begin
                m[i] = up ? (i > int'(f)) : (i < int'(f));
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/elevator_scheduler_timer.sv
// Loadable down-counter shared by the travel and door phases.
module elev_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_load,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count <= i_load;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-policy floor scheduler: latches key presses, moves the car one floor at a time, cycles the door.
// state | meaning
// IDLE  | no pending work, car parked
// MOVE  | travelling one floor per MOVE_CYCLES
// DOOR  | door open at current floor for DOOR_CYCLES
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS      = 16,
    parameter int MOVE_CYCLES = 32,
    parameter int DOOR_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLOOR_W-1:0]    key_code,
    input  logic                  key_valid,
    input  logic                  door_hold,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open,
    output logic [MAX_FLOORS-1:0] requests
);

    localparam int TMR_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] MOVE_LOAD = TMR_W'(MOVE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DOOR_LOAD = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [MAX_FLOORS-1:0] FLOOR_MASK = MAX_FLOORS'((64'd1 << FLOORS) - 64'd1);

    state_t                r_state, w_next_state;
    logic [FLOOR_W-1:0]    r_floor, w_next_floor, w_step_floor, w_clr_idx;
    logic                  r_dir_up, w_next_dir;
    logic [MAX_FLOORS-1:0] r_requests, w_set_vec, w_clr_vec;
    logic [MAX_FLOORS-1:0] w_up_req, w_dn_req, w_fwd_req, w_back_req;
    logic                  r_key_prev;
    logic                  w_press, w_press_here, w_key_ok;
    logic                  w_clr_en, w_decide;
    logic                  w_tmr_start, w_tmr_done;
    logic [TMR_W-1:0]      w_tmr_load;

    elev_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_tmr_start),
        .i_load  (w_tmr_load),
        .o_done  (w_tmr_done)
    );

    assign w_press      = key_valid & ~r_key_prev;
    assign w_key_ok     = int'(key_code) < FLOORS;
    // A press for the floor whose door is open keeps the door open instead of queuing.
    assign w_press_here = w_press && (r_state == DOOR) && (key_code == r_floor);
    assign w_set_vec    = (w_press && w_key_ok && !w_press_here) ? (MAX_FLOORS'(1) << key_code) : '0;
    assign w_clr_vec    = w_clr_en ? (MAX_FLOORS'(1) << w_clr_idx) : '0;

    assign w_up_req     = ahead_mask(r_floor, 1'b1, FLOORS) & r_requests;
    assign w_dn_req     = ahead_mask(r_floor, 1'b0, FLOORS) & r_requests;
    assign w_step_floor = r_dir_up ? (r_floor + 4'd1) : (r_floor - 4'd1);
    assign w_fwd_req    = ahead_mask(w_step_floor, r_dir_up, FLOORS) & r_requests;
    assign w_back_req   = ahead_mask(w_step_floor, ~r_dir_up, FLOORS) & r_requests;

    always_comb begin
        w_next_state = r_state;
        w_next_floor = r_floor;
        w_next_dir   = r_dir_up;
        w_clr_en     = 1'b0;
        w_clr_idx    = r_floor;
        w_tmr_start  = 1'b0;
        w_tmr_load   = MOVE_LOAD;
        w_decide     = 1'b0;
        case (r_state)
            IDLE: w_decide = 1'b1;
            MOVE: begin
                if (w_tmr_done) begin
                    w_next_floor = w_step_floor;
                    if (r_requests[w_step_floor]) begin
                        w_clr_en     = 1'b1;
                        w_clr_idx    = w_step_floor;
                        w_next_state = DOOR;
                        w_tmr_start  = 1'b1;
                        w_tmr_load   = DOOR_LOAD;
                    end else if (|w_fwd_req) begin
                        w_tmr_start  = 1'b1;
                    end else if (|w_back_req) begin
                        w_next_dir   = ~r_dir_up;
                        w_tmr_start  = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            DOOR: begin
                if (door_hold || w_press_here) begin
                    w_tmr_start = 1'b1;
                    w_tmr_load  = DOOR_LOAD;
                end else if (w_tmr_done) begin
                    w_decide    = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase

        // Parked decision, shared by IDLE and door close; keeps current direction on a tie.
        if (w_decide) begin
            if (r_requests == '0) begin
                w_next_state = IDLE;
            end else if (r_requests[r_floor]) begin
                w_clr_en     = 1'b1;
                w_next_state = DOOR;
                w_tmr_start  = 1'b1;
                w_tmr_load   = DOOR_LOAD;
            end else begin
                w_next_state = MOVE;
                w_next_dir   = (|w_up_req) && (r_dir_up || !(|w_dn_req));
                w_tmr_start  = 1'b1;
                w_tmr_load   = MOVE_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_floor    <= '0;
            r_dir_up   <= 1'b1;
            r_requests <= '0;
            r_key_prev <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_floor    <= w_next_floor;
            r_dir_up   <= w_next_dir;
            r_requests <= (r_requests | w_set_vec) & ~w_clr_vec & FLOOR_MASK;
            r_key_prev <= key_valid;
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        (r_state == MOVE && w_tmr_done) |-> ((r_dir_up ? w_up_req : w_dn_req) != '0));

    assign floor     = r_floor;
    assign moving    = (r_state == MOVE);
    assign dir_up    = r_dir_up;
    assign door_open = (r_state == DOOR);
    assign requests  = r_requests;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: vector tables plus hand-written multi-cycle sequences.
module tb_elevator_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_code = '0;
    logic        key_valid = 1'b0;
    logic        door_hold = 1'b0;

    logic [3:0]  floor, floor8;
    logic        moving, moving8, dir_up, dir_up8, door_open, door_open8;
    logic [15:0] requests, requests8;

    int n_checks = 0;
    int n_fail   = 0;

    elevator_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_valid (key_valid),
        .door_hold (door_hold),
        .floor     (floor),
        .moving    (moving),
        .dir_up    (dir_up),
        .door_open (door_open),
        .requests  (requests)
    );

    elevator_scheduler #(.FLOORS(8), .MOVE_CYCLES(4), .DOOR_CYCLES(4)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_valid (key_valid),
        .door_hold (door_hold),
        .floor     (floor8),
        .moving    (moving8),
        .dir_up    (dir_up8),
        .door_open (door_open8),
        .requests  (requests8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  kc;
        logic        kv;
        int          n;
        logic [3:0]  f;
        logic        m;
        logic        u;
        logic        d;
        logic [15:0] r;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic [3:0] kc, input logic kv, input int n,
                                input logic [3:0] f, input logic m, input logic u,
                                input logic d, input logic [15:0] r);
        vec_t v;
        v.kc = kc; v.kv = kv; v.n = n;
        v.f = f; v.m = m; v.u = u; v.d = d; v.r = r;
        return v;
    endfunction

    function automatic logic [31:0] pack(input logic [3:0] f, input logic m, input logic u,
                                         input logic d, input logic [15:0] r);
        return {9'd0, f, m, u, d, r};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            key_code  = vecs[i].kc;
            key_valid = vecs[i].kv;
            tick(vecs[i].n);
            check($sformatf("vec%0d", i),
                  pack(floor, moving, dir_up, door_open, requests),
                  pack(vecs[i].f, vecs[i].m, vecs[i].u, vecs[i].d, vecs[i].r));
        end
    endtask

    initial begin
        int   rises;
        int   bad;
        logic prev_door;

        // Press 5 from floor 0: travel 5 floors, one door cycle, back to idle.
        vecs[0]  = mk(4'd5, 1'b1,   1, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0020);
        vecs[1]  = mk(4'd0, 1'b0,   1, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0020);
        vecs[2]  = mk(4'd0, 1'b0,  31, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0020);
        vecs[3]  = mk(4'd0, 1'b0,   1, 4'd1, 1'b1, 1'b1, 1'b0, 16'h0020);
        vecs[4]  = mk(4'd0, 1'b0, 127, 4'd4, 1'b1, 1'b1, 1'b0, 16'h0020);
        vecs[5]  = mk(4'd0, 1'b0,   1, 4'd5, 1'b0, 1'b1, 1'b1, 16'h0000);
        vecs[6]  = mk(4'd0, 1'b0,  63, 4'd5, 1'b0, 1'b1, 1'b1, 16'h0000);
        vecs[7]  = mk(4'd0, 1'b0,   1, 4'd5, 1'b0, 1'b1, 1'b0, 16'h0000);
        // From floor 3: go to 4, re-press 4 with door open, queue 7 and 2, serve 7 then 2.
        vecs[8]  = mk(4'd4, 1'b1,   1, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0010);
        vecs[9]  = mk(4'd0, 1'b0,   1, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0010);
        vecs[10] = mk(4'd0, 1'b0,  32, 4'd4, 1'b0, 1'b1, 1'b1, 16'h0000);
        vecs[11] = mk(4'd0, 1'b0,   6, 4'd4, 1'b0, 1'b1, 1'b1, 16'h0000);
        vecs[12] = mk(4'd4, 1'b1,   1, 4'd4, 1'b0, 1'b1, 1'b1, 16'h0000);
        vecs[13] = mk(4'd0, 1'b0,   2, 4'd4, 1'b0, 1'b1, 1'b1, 16'h0000);
        vecs[14] = mk(4'd7, 1'b1,   1, 4'd4, 1'b0, 1'b1, 1'b1, 16'h0080);
        vecs[15] = mk(4'd0, 1'b0,   2, 4'd4, 1'b0, 1'b1, 1'b1, 16'h0080);
        vecs[16] = mk(4'd2, 1'b1,   1, 4'd4, 1'b0, 1'b1, 1'b1, 16'h0084);
        vecs[17] = mk(4'd0, 1'b0,  57, 4'd4, 1'b0, 1'b1, 1'b1, 16'h0084);
        vecs[18] = mk(4'd0, 1'b0,   1, 4'd4, 1'b1, 1'b1, 1'b0, 16'h0084);
        vecs[19] = mk(4'd0, 1'b0,  96, 4'd7, 1'b0, 1'b1, 1'b1, 16'h0004);
        vecs[20] = mk(4'd0, 1'b0,  63, 4'd7, 1'b0, 1'b1, 1'b1, 16'h0004);
        vecs[21] = mk(4'd0, 1'b0,   1, 4'd7, 1'b1, 1'b0, 1'b0, 16'h0004);
        vecs[22] = mk(4'd0, 1'b0, 160, 4'd2, 1'b0, 1'b0, 1'b1, 16'h0000);
        vecs[23] = mk(4'd0, 1'b0,  64, 4'd2, 1'b0, 1'b0, 1'b0, 16'h0000);

        tick(2);
        check("reset_state", pack(floor, moving, dir_up, door_open, requests),
              pack(4'd0, 1'b0, 1'b1, 1'b0, 16'h0000));
        rst = 1'b1;

        // Out-of-range key on the 8-floor car, then reset in the middle of a move.
        key_code = 4'd12; key_valid = 1'b1; tick(1);
        check("key12_ignored_8fl", {16'd0, requests8}, 32'h0000);
        check("key12_taken_16fl", {16'd0, requests}, 32'h1000);
        key_valid = 1'b0; tick(1);
        key_code = 4'd7; key_valid = 1'b1; tick(1);
        check("key7_taken_8fl", {16'd0, requests8}, 32'h0080);
        key_valid = 1'b0; tick(40);
        check("mid_move", pack(floor, moving, dir_up, door_open, requests),
              pack(4'd1, 1'b1, 1'b1, 1'b0, 16'h1080));
        #2 rst = 1'b0;
        #1;
        check("async_reset", pack(floor, moving, dir_up, door_open, requests),
              pack(4'd0, 1'b0, 1'b1, 1'b0, 16'h0000));
        check("async_reset_8fl", pack(floor8, moving8, dir_up8, door_open8, requests8),
              pack(4'd0, 1'b0, 1'b1, 1'b0, 16'h0000));
        tick(2);
        rst = 1'b1;

        run_vecs(0, 7);

        // Hold key 3 for 100 cycles: one request, one door cycle.
        key_code = 4'd3; key_valid = 1'b1;
        rises = 0;
        prev_door = door_open;
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (i == 1) check("hold_key_req", {16'd0, requests}, 32'h0008);
            if (i == 100) key_valid = 1'b0;
            if (door_open && !prev_door) rises++;
            prev_door = door_open;
        end
        check("hold_key_door_cycles", rises, 1);
        check("hold_key_end", pack(floor, moving, dir_up, door_open, requests),
              pack(4'd3, 1'b0, 1'b0, 1'b0, 16'h0000));

        run_vecs(8, 23);

        // door_hold for 200 cycles, then door closes DOOR_CYCLES after release.
        key_code = 4'd2; key_valid = 1'b1; tick(1);
        check("same_floor_req_idle", {16'd0, requests}, 32'h0004);
        key_valid = 1'b0; tick(1);
        check("same_floor_door", pack(floor, moving, dir_up, door_open, requests),
              pack(4'd2, 1'b0, 1'b0, 1'b1, 16'h0000));
        door_hold = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (!door_open) bad++;
        end
        check("door_held_open", bad, 0);
        door_hold = 1'b0;
        tick(63);
        check("door_open_after_release", {31'd0, door_open}, 32'd1);
        tick(1);
        check("door_closed_after_release", pack(floor, moving, dir_up, door_open, requests),
              pack(4'd2, 1'b0, 1'b0, 1'b0, 16'h0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
